xrv_mem_arb: RTL and testbench

Two-port memory arbiter placed between the xrv core and a single-port synchronous RAM. The instruction-fetch port and the execute-stage load/store port both share one memory. The arbiter grants one access at a time and issues it to the RAM from registered copies of the request. It then returns a one-cycle ready pulse with read data to the granted requester. Arbitration is fixed-priority (data over fetch) by default, or round-robin when compiled in.

---
 rtl/xrv_mem_arb.sv | 132 +++++++++++++
 tb/tb_xrv_mem_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xrv_mem_arb.sv
// Two-port memory arbiter (instruction fetch vs. execute load/store) in front of a single-port sync RAM.
// Fixed priority data-over-fetch by default; define XRV_ARB_RR_EN to build the round-robin variant.
module xrv_mem_arb #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rd_data,
    input  logic              d_rd_req,
    input  logic              d_wr_req,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wr_data,
    output logic              d_rd_ready,
    output logic              d_wr_ready,
    output logic [31:0]       d_rd_data,
    output logic [ADDR_W-3:0] m_addr,
    output logic              m_rd_en,
    output logic              m_wr_en,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wr_data,
    input  logic [31:0]       m_rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;
    typedef enum logic [1:0] {G_FETCH, G_LOAD, G_STORE} grant_e;

    state_e            state_q;
    grant_e            grant_q;
    grant_e            win;
    logic              data_req;
    logic              any_req;
    logic [ADDR_W-3:0] win_addr;
    logic [ADDR_W-3:0] m_addr_q;
    logic [3:0]        m_be_q;
    logic [31:0]       m_wr_data_q;
    logic              m_rd_en_q;
    logic              m_wr_en_q;
    logic              i_ready_q;
    logic              d_rd_ready_q;
    logic              d_wr_ready_q;
    logic              unused_addr_bits;

    assign data_req = d_rd_req | d_wr_req;
    assign any_req  = data_req | i_req;

`ifdef XRV_ARB_RR_EN
    logic last_fetch_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        win = d_wr_req ? G_STORE : G_LOAD;
        if (i_req && (!data_req || !last_fetch_q))
            win = G_FETCH;
    end
`else
    always_comb begin
        win = d_wr_req ? G_STORE : G_LOAD;
        if (!data_req)
            win = G_FETCH;
    end
`endif

    assign win_addr = (win == G_FETCH) ? i_addr[ADDR_W-1:2] : d_addr[ADDR_W-1:2];

    // Address bits outside the RAM word range are deliberately ignored (address wraps).
    assign unused_addr_bits = ^{i_addr[31:ADDR_W], i_addr[1:0], d_addr[31:ADDR_W], d_addr[1:0]};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            grant_q      <= G_FETCH;
            m_addr_q     <= '0;
            m_be_q       <= '0;
            m_wr_data_q  <= '0;
            m_rd_en_q    <= 1'b0;
            m_wr_en_q    <= 1'b0;
            i_ready_q    <= 1'b0;
            d_rd_ready_q <= 1'b0;
            d_wr_ready_q <= 1'b0;
`ifdef XRV_ARB_RR_EN
            last_fetch_q <= 1'b1;
`endif
        end else begin
            m_rd_en_q    <= 1'b0;
            m_wr_en_q    <= 1'b0;
            i_ready_q    <= 1'b0;
            d_rd_ready_q <= 1'b0;
            d_wr_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        grant_q   <= win;
                        m_addr_q  <= win_addr;
                        m_be_q    <= (win == G_STORE) ? d_be : 4'hf;
                        if (win == G_STORE)
                            m_wr_data_q <= d_wr_data;
                        m_rd_en_q <= (win != G_STORE);
                        m_wr_en_q <= (win == G_STORE);
`ifdef XRV_ARB_RR_EN
                        last_fetch_q <= (win == G_FETCH);
`endif
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    i_ready_q    <= (grant_q == G_FETCH);
                    d_rd_ready_q <= (grant_q == G_LOAD);
                    d_wr_ready_q <= (grant_q == G_STORE);
                    state_q      <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_addr     = m_addr_q;
    assign m_be       = m_be_q;
    assign m_wr_data  = m_wr_data_q;
    assign m_rd_en    = m_rd_en_q;
    assign m_wr_en    = m_wr_en_q;
    assign i_ready    = i_ready_q;
    assign d_rd_ready = d_rd_ready_q;
    assign d_wr_ready = d_wr_ready_q;
    assign i_rd_data  = m_rd_data;
    assign d_rd_data  = m_rd_data;

endmodule

// File: tb/tb_xrv_mem_arb.sv
// Bench for xrv_mem_arb: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (one access in flight, strobe one cycle after grant, ready one after that).
module tb_xrv_mem_arb;

    localparam int ADDR_W = 16;
    localparam int WORDS  = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rstb = 1'b1;
    logic              i_req, d_rd_req, d_wr_req;
    logic [31:0]       i_addr, d_addr, d_wr_data;
    logic [3:0]        d_be;
    logic              i_ready, d_rd_ready, d_wr_ready;
    logic [31:0]       i_rd_data, d_rd_data;
    logic [ADDR_W-3:0] m_addr;
    logic              m_rd_en, m_wr_en;
    logic [3:0]        m_be;
    logic [31:0]       m_wr_data, m_rd_data;

    xrv_mem_arb #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstb(rstb),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rd_data(i_rd_data),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_be(d_be),
        .d_wr_data(d_wr_data), .d_rd_ready(d_rd_ready), .d_wr_ready(d_wr_ready),
        .d_rd_data(d_rd_data), .m_addr(m_addr), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
        .m_be(m_be), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT, 1-cycle read latency.
    logic [31:0] ram [0:WORDS-1];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (m_wr_en)
            for (int b = 0; b < 4; b++)
                if (m_be[b]) ram[m_addr][8*b +: 8] <= m_wr_data[8*b +: 8];
        if (m_rd_en) ram_q <= ram[m_addr];
    end
    assign m_rd_data = ram_q;

    // Reference model state.
    logic [31:0]       ref_mem [0:WORDS-1];
    int                total = 0, bad = 0, cyc = 0;
    int                strobe_cyc, free_cyc, g_kind;  // g_kind: 0 fetch, 1 load, 2 store
    logic [ADDR_W-3:0] exp_addr;
    logic [3:0]        exp_be;
    logic [31:0]       exp_wdata, exp_rdata;
    logic              last_fetch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    task automatic model_reset();
        strobe_cyc = -100;
        free_cyc   = 0;
        g_kind     = 0;
        exp_addr   = '0;
        exp_be     = '0;
        exp_wdata  = '0;
        exp_rdata  = '0;
        last_fetch = 1'b1;
    endtask

    task automatic check_outputs();
        bit strobe, rdy;
        strobe = (cyc == strobe_cyc);
        rdy    = (cyc == strobe_cyc + 1);
        check("m_rd_en",    32'(m_rd_en),    32'(strobe && g_kind != 2));
        check("m_wr_en",    32'(m_wr_en),    32'(strobe && g_kind == 2));
        check("m_addr",     32'(m_addr),     32'(exp_addr));
        check("m_be",       32'(m_be),       32'(exp_be));
        check("m_wr_data",  m_wr_data,       exp_wdata);
        check("i_ready",    32'(i_ready),    32'(rdy && g_kind == 0));
        check("d_rd_ready", 32'(d_rd_ready), 32'(rdy && g_kind == 1));
        check("d_wr_ready", 32'(d_wr_ready), 32'(rdy && g_kind == 2));
        if (rdy && g_kind == 0) check("i_rd_data", i_rd_data, exp_rdata);
        if (rdy && g_kind == 1) check("d_rd_data", d_rd_data, exp_rdata);
    endtask

    // Arbitration decision for the current cycle's inputs, taken only when the arbiter is free.
    task automatic decide();
        bit data, take_fetch;
        int k, w;
        logic [31:0] a;
        data = d_rd_req || d_wr_req;
        if (cyc < free_cyc || !(data || i_req)) return;
`ifdef XRV_ARB_RR_EN
        take_fetch = i_req && (!data || !last_fetch);
`else
        take_fetch = i_req && !data;
`endif
        k = take_fetch ? 0 : (d_wr_req ? 2 : 1);
        a = take_fetch ? i_addr : d_addr;
        w = word_of(a);
        exp_addr = w[ADDR_W-3:0];
        if (k == 2) begin
            exp_be    = d_be;
            exp_wdata = d_wr_data;
            for (int b = 0; b < 4; b++)
                if (d_be[b]) ref_mem[w][8*b +: 8] = d_wr_data[8*b +: 8];
        end else begin
            exp_be    = 4'hf;
            exp_rdata = ref_mem[w];
        end
        g_kind     = k;
        strobe_cyc = cyc + 1;
        free_cyc   = cyc + 3;
        last_fetch = (k == 0);
    endtask

    task automatic step();
        check_outputs();
        decide();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd);
        i_req = ir; i_addr = ia; d_rd_req = dr; d_wr_req = dw;
        d_addr = da; d_be = be; d_wr_data = wd;
    endtask

    task automatic idle_n(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    // Asserted at a negedge; outputs must be at reset values 1 ns later, not at the next edge.
    task automatic apply_reset();
        rstb = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        logic [13:0] w;
        w = 14'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) w = w | 14'h3ff0;
        a = $urandom;
        a[ADDR_W-1:2] = w;
        return a;
    endfunction

    bit          f_on, f_drop, d_on, d_drop, ready_f, ready_d, granted_f, granted_d;
    logic [31:0] f_addr, dd_addr, dd_wd;
    logic [3:0]  dd_be;
    bit          dd_rd, dd_wr;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i]     = 32'(i) * 32'h9e37_79b9;
            ref_mem[i] = 32'(i) * 32'h9e37_79b9;
        end
        ram[32'h40] = 32'h1234_5678;  ref_mem[32'h40] = 32'h1234_5678;
        ram[32'h81] = 32'h1122_3344;  ref_mem[32'h81] = 32'h1122_3344;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        apply_reset();

        // Lone fetch.
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        step(); step();
        check("fetch_ready", 32'(i_ready), 32'd1);
        check("fetch_data", i_rd_data, 32'h1234_5678);
        step();
        idle_n(2);

        // Store then load of the same word.
        drive(0, 0, 0, 1, 32'h204, 4'h6, 32'h00ab_cd00);
        step(); step(); step();
        idle_n(1);
        drive(0, 0, 1, 0, 32'h204, 0, 0);
        step(); step();
        check("merge_data", d_rd_data, 32'h11ab_cd44);
        step();
        idle_n(1);

        // Fetch request seen only while the arbiter is in RESP of a load.
        drive(0, 0, 1, 0, 32'h208, 0, 0);
        step(); step();
        drive(1, 32'h300, 1, 0, 32'h208, 0, 0);
        step();
        idle_n(4);

        // Reset during ISSUE of a load.
        drive(0, 0, 1, 0, 32'h20c, 0, 0);
        step();
        check_outputs();
        apply_reset();
        idle_n(3);
        drive(0, 0, 1, 0, 32'h20c, 0, 0);
        step(); step();
        check("post_rst_ready", 32'(d_rd_ready), 32'd1);
        step();
        idle_n(1);

        // Simultaneous fetch and load from a fresh reset: data first, fetch second.
        apply_reset();
        drive(1, 32'h100, 1, 0, 32'h204, 0, 0);
        step(); step();
        check("cont_load_first", 32'(d_rd_ready), 32'd1);
        step();
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        step(); step();
        check("cont_fetch_second", 32'(i_ready), 32'd1);
        step();
        idle_n(1);

        // Random traffic from two protocol-following requesters.
        f_on = 0; f_drop = 0; d_on = 0; d_drop = 0;
        f_addr = 0; dd_addr = 0; dd_wd = 0; dd_be = 0; dd_rd = 0; dd_wr = 0;
        for (int n = 0; n < 3000; n++) begin
            ready_f   = (cyc == strobe_cyc + 1) && g_kind == 0;
            ready_d   = (cyc == strobe_cyc + 1) && g_kind != 0;
            granted_f = (cyc >= strobe_cyc) && (cyc <= strobe_cyc + 1) && g_kind == 0;
            granted_d = (cyc >= strobe_cyc) && (cyc <= strobe_cyc + 1) && g_kind != 0;
            if (f_drop) begin
                f_on = 0; f_drop = 0;
            end else if (f_on) begin
                if (ready_f) f_drop = 1;
                else if (!granted_f && $urandom_range(0, 15) == 0) f_on = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                f_on = 1; f_addr = rand_addr();
            end
            if (d_drop) begin
                d_on = 0; d_drop = 0;
            end else if (d_on) begin
                if (ready_d) d_drop = 1;
                else if (!granted_d && $urandom_range(0, 15) == 0) d_on = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                int r;
                r = $urandom_range(0, 15);
                d_on = 1; dd_addr = rand_addr(); dd_wd = $urandom; dd_be = 4'($urandom);
                dd_rd = (r < 8) || (r == 15);
                dd_wr = (r >= 8);
            end
            drive(f_on, f_addr, d_on && dd_rd, d_on && dd_wr, dd_addr, dd_be, dd_wd);
            step();
        end
        idle_n(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
